// File: rtl/gnn_result_collector_if.sv
// Result-collector bus: parallel result capture inputs plus the serial tx stream.
// The collector uses the master modport; the environment uses the slave modport.
interface gnn_result_collector_if;
  logic [167:0] res_data;
  logic [7:0]   res_ready;
  logic [20:0]  tx_data;
  logic [3:0]   tx_idx;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;
  logic         overflow;

  modport master (
    input  res_data, res_ready, tx_ready,
    output tx_data, tx_idx, tx_valid, busy, done, overflow
  );

  modport slave (
    output res_data, res_ready, tx_ready,
    input  tx_data, tx_idx, tx_valid, busy, done, overflow
  );
endinterface

// File: rtl/gnn_result_collector.sv
// Collects eight signed GNN results, then streams them plus a per-node class word.
// All outputs are registered; overflow flags results that arrive outside COLLECT.
module gnn_result_collector (
  input  logic                          clk,
  input  logic                          rst,
  gnn_result_collector_if.master        bus_io
);

  typedef enum logic [1:0] {COLLECT, SEND, DONE} state_e;

  state_e             state_q;
  logic signed [20:0] slot_q [8];
  logic signed [20:0] slot_d [8];
  logic [7:0]         captured_q;
  logic [7:0]         captured_d;
  logic [7:0]         newCap;
  logic [3:0]         beatIdx_q;
  logic [20:0]        txData_q;
  logic               txValid_q;
  logic               busy_q;
  logic               done_q;
  logic               overflow_q;
  logic [3:0]         cls;

  // A level-held ready on an already captured slot is not a new result.
  always_comb begin
    newCap     = (state_q == COLLECT) ? (bus_io.res_ready & ~captured_q) : 8'h00;
    captured_d = captured_q | newCap;
    for (int k = 0; k < 8; k++) begin
      slot_d[k] = newCap[k] ? $signed(bus_io.res_data[21*k +: 21]) : slot_q[k];
    end
  end

  always_comb begin
    cls = 4'h0;
    for (int n = 0; n < 4; n++) begin
      cls[n] = (slot_q[2*n+1] > slot_q[2*n]);
    end
  end

  function automatic logic [20:0] beatWord(input logic [3:0] idx);
    if (idx < 4'd8) begin
      return slot_q[idx[2:0]];
    end
    return {17'b0, cls};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      for (int k = 0; k < 8; k++) begin
        slot_q[k] <= '0;
      end
      captured_q <= 8'h00;
      beatIdx_q  <= 4'd0;
      txData_q   <= 21'd0;
      txValid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          for (int k = 0; k < 8; k++) begin
            slot_q[k] <= slot_d[k];
          end
          captured_q <= captured_d;
          // Slots captured on the filling edge must already feed beat 0.
          if (captured_d == 8'hFF) begin
            state_q   <= SEND;
            busy_q    <= 1'b1;
            txValid_q <= 1'b1;
            beatIdx_q <= 4'd0;
            txData_q  <= slot_d[0];
          end
        end
        SEND: begin
          if (|bus_io.res_ready) begin
            overflow_q <= 1'b1;
          end
          if (txValid_q && bus_io.tx_ready) begin
            if (beatIdx_q == 4'd8) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              txValid_q <= 1'b0;
              txData_q  <= 21'd0;
              beatIdx_q <= 4'd0;
              done_q    <= 1'b1;
            end else begin
              beatIdx_q <= beatIdx_q + 4'd1;
              txData_q  <= beatWord(beatIdx_q + 4'd1);
            end
          end
        end
        DONE: begin
          if (|bus_io.res_ready) begin
            overflow_q <= 1'b1;
          end
          captured_q <= 8'h00;
          beatIdx_q  <= 4'd0;
          state_q    <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus_io.tx_data  = txData_q;
  assign bus_io.tx_idx   = beatIdx_q;
  assign bus_io.tx_valid = txValid_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.overflow = overflow_q;

endmodule

// File: doc/gnn_result_collector.md
GNN_RESULT_COLLECTOR -- requirements
Module: gnn_result_collector

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; every flop is rising-edge.
REQ-002 SHALL have `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have `res_data`, input, 168 bits: 8 signed 21-bit results; slot k occupies bits [21k+20:21k]; k = 2*node + out (node 0..3, out 0..1).
REQ-004 SHALL have `res_ready`, input, 8 bits: bit k is the ready flag for slot k, single-cycle or level.
REQ-005 SHALL have `tx_data`, output, 21 bits: signed result word being offered.
REQ-006 SHALL have `tx_idx`, output, 4 bits: slot index of `tx_data`; 0..7 are results, 8 is the class word.
REQ-007 SHALL have `tx_valid`, output, 1 bit: `tx_data`/`tx_idx` are valid.
REQ-008 SHALL have `tx_ready`, input, 1 bit: the sink accepts the beat when `tx_valid` and `tx_ready` are both high.
REQ-009 SHALL have `busy`, output, 1 bit: high in SEND.
REQ-010 SHALL have `done`, output, 1 bit: single-cycle pulse after the class word is accepted.
REQ-011 SHALL have `overflow`, output, 1 bit: sticky; a result was dropped.

Function
REQ-012 SHALL implement FSM states COLLECT, SEND and DONE.
REQ-013 SHALL keep eight 21-bit capture registers plus an 8-bit `captured` mask.
REQ-014 In COLLECT, SHALL load slot k from `res_data` and set `captured[k]` on a clock edge where `res_ready[k]`=1 and `captured[k]`=0.
REQ-015 In COLLECT, SHALL leave slot k unchanged if `res_ready[k]`=1 while `captured[k]`=1 (level-held flag); no overflow is raised in this case.
REQ-016 SHALL handle multiple `res_ready` bits in one cycle by capturing all eligible slots in that same cycle.
REQ-017 SHALL go COLLECT->SEND on the edge after `captured` becomes 8'hFF; the slots captured on that edge are included.
REQ-018 In SEND, SHALL drive `tx_valid`=1 starting in the first SEND cycle, with the beat index starting at 0.
REQ-019 SHALL present beats in order, index 0..8; `tx_idx` SHALL equal the beat index.
REQ-020 SHALL advance the beat index only on an accepted beat (`tx_valid` and `tx_ready` high).
REQ-021 SHALL hold `tx_data` and `tx_idx` stable while `tx_valid`=1 and `tx_ready`=0.
REQ-022 For beats 0..7, SHALL drive `tx_data` with capture register k.
REQ-023 For beat 8, SHALL drive `tx_data` with {17'b0, cls[3:0]}, where cls[n]=1 iff slot 2n+1 > slot 2n under signed compare.
REQ-024 SHALL break class ties to 0 (equal values give cls[n]=0).
REQ-025 SHALL produce back-to-back beats, one per cycle, while `tx_ready` is held at 1; beat 8 is therefore accepted 9 cycles after SEND entry.
REQ-026 SHALL go SEND->DONE on acceptance of beat 8.
REQ-027 In DONE (one cycle), SHALL assert `done`=1, clear `captured` and the beat index, and return to COLLECT.
REQ-028 In SEND or DONE, SHALL ignore every `res_ready[k]`=1 (nothing captured) and set `overflow`=1.
REQ-029 SHALL clear `overflow` only by `rst`.
REQ-030 SHALL drive `tx_valid`=0 outside SEND, with `tx_data` and `tx_idx` equal to 0 there.

Reset
REQ-031 On `rst`=1, SHALL immediately enter COLLECT.
REQ-032 On `rst`=1, SHALL clear the capture registers, `captured` and the beat index.
REQ-033 On `rst`=1, SHALL clear `tx_valid`, `tx_data`, `tx_idx`, `busy`, `done` and `overflow` to 0.
REQ-034 SHALL, on `rst` asserted mid-SEND, abandon the in-flight beat; the next frame restarts at index 0.
REQ-035 SHALL start capturing on the first clock edge after `rst` deasserts.

Verification
REQ-036 Full frame: all 8 `res_ready` pulsed in one cycle with slot k = k*100-300, `tx_ready`=1 -> 9 consecutive beats, values -300,-200,...,400.
REQ-036a Full frame, class word: same stimulus as REQ-036 -> class word 4'hF, then `done` pulse; `overflow`=0.
REQ-037 Staggered capture with stall: ready pulsed one slot per cycle in order 7..0, `tx_ready` toggled 1/0 -> data stable during stalls; `tx_idx` sequence 0..8 with no skips.
REQ-038 Signed/tie class: slot0=-5, slot1=-5; slot2=1048575, slot3=-1048576; slot4=-1, slot5=0; slot6=3, slot7=3 -> class word 4'b0100.
REQ-039 Overflow: `res_ready[3]` pulsed during SEND -> `overflow`=1 and stays set across the next frame.
REQ-039a Overflow, data intact: same stimulus as REQ-039 -> the frame's slot-3 data is unchanged.
REQ-040 Mid-SEND reset: `rst` asserted after beat 4 is accepted -> all outputs 0 asynchronously; a new full frame then starts at `tx_idx`=0.
